// File: rtl/bus_master_if_pkg.sv
// Shared definitions for the per-master bus interface: FSM state encoding,
// active-low bus levels, read/write levels and default widths.
package bus_master_if_pkg;

  // Controller states, 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_REQ    = 2'b01,
    ST_ACCESS = 2'b10,
    ST_STALL  = 2'b11
  } state_t;

  // Active-low control levels used on the shared bus
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // Direction levels for cpu_rw / bus_rw
  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  // Default widths and watchdog limit
  localparam int DEF_ADDR_W  = 30;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 255;

  // Bits needed to count 0 .. timeout-1 access cycles
  function automatic int wd_width(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/bus_master_if_if.sv
// Bus-side signal bundle between one master and the shared bus
// (arbiter handshake plus address/data phase). The master modport is
// used by bus_master_if, the slave modport by the bus/arbiter side.
import bus_master_if_pkg::*;

interface bus_master_if_if #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              bus_req_;
  logic              bus_grnt_;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_as_;
  logic              bus_rw;
  logic [DATA_W-1:0] bus_wr_data;
  logic [DATA_W-1:0] bus_rd_data;
  logic              bus_rdy_;

  modport master (
    output bus_req_,
    output bus_addr,
    output bus_as_,
    output bus_rw,
    output bus_wr_data,
    input  bus_grnt_,
    input  bus_rd_data,
    input  bus_rdy_
  );

  modport slave (
    input  bus_req_,
    input  bus_addr,
    input  bus_as_,
    input  bus_rw,
    input  bus_wr_data,
    output bus_grnt_,
    output bus_rd_data,
    output bus_rdy_
  );

endinterface

// File: rtl/bus_master_if_watchdog.sv
// Access watchdog: counts cycles spent waiting for the slave and flags
// expiry in the TIMEOUT-th counted cycle so the controller can abort.
import bus_master_if_pkg::*;

module bus_master_if_watchdog #(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW   = wd_width(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Count enabled cycles; any cycle outside an access restarts from zero
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/bus_master_if.sv
// Per-master bus interface: converts a one-cycle CPU access request into
// an arbitrated bus transaction (request, grant, address strobe, ready),
// returns read data, stalls the pipeline meanwhile and aborts hung
// accesses through the watchdog.
import bus_master_if_pkg::*;

module bus_master_if #(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               cpu_req,
  input  logic               cpu_rw,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [DATA_W-1:0]  cpu_wr_data,
  output logic [DATA_W-1:0]  cpu_rd_data,
  output logic               cpu_busy,
  output logic               bus_err,
  bus_master_if_if.master    bus
);

  state_t            state;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_rw;
  logic [DATA_W-1:0] lat_wr_data;
  logic              wd_clear;
  logic              wd_enable;
  logic              wd_expired;
  logic              rdy_seen;

  assign wd_enable = (state == ST_ACCESS);
  assign wd_clear  = (state != ST_ACCESS);
  assign rdy_seen  = (bus.bus_rdy_ == ENABLE_);

  bus_master_if_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  // Pipeline wait: a new request stalls immediately, the bus phases always
  // stall, and a held result (STALL) lets the pipeline see the data
  always_comb begin
    cpu_busy = 1'b0;
    case (state)
      ST_IDLE:           cpu_busy = cpu_req && !flush;
      ST_REQ, ST_ACCESS: cpu_busy = 1'b1;
      default:           cpu_busy = 1'b0;
    endcase
  end

  // Transaction FSM with all bus outputs registered; the bus is only
  // driven (as_, addr, wr_data) while this master owns it
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      bus.bus_req_    <= DISABLE_;
      bus.bus_as_     <= DISABLE_;
      bus.bus_rw      <= READ;
      bus.bus_addr    <= '0;
      bus.bus_wr_data <= '0;
      cpu_rd_data     <= '0;
      bus_err         <= 1'b0;
      lat_addr        <= '0;
      lat_rw          <= READ;
      lat_wr_data     <= '0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cpu_req && !flush) begin
            lat_addr     <= cpu_addr;
            lat_rw       <= cpu_rw;
            lat_wr_data  <= cpu_wr_data;
            bus.bus_req_ <= ENABLE_;
            state        <= ST_REQ;
          end
        end

        ST_REQ: begin
          if (bus.bus_grnt_ == ENABLE_) begin
            bus.bus_addr    <= lat_addr;
            bus.bus_rw      <= lat_rw;
            bus.bus_wr_data <= lat_wr_data;
            bus.bus_as_     <= ENABLE_;
            state           <= ST_ACCESS;
          end
        end

        ST_ACCESS: begin
          bus.bus_as_ <= DISABLE_;
          if (rdy_seen) begin
            if (bus.bus_rw == READ) begin
              cpu_rd_data <= bus.bus_rd_data;
            end
            bus.bus_req_    <= DISABLE_;
            bus.bus_rw      <= READ;
            bus.bus_addr    <= '0;
            bus.bus_wr_data <= '0;
            state           <= stall ? ST_STALL : ST_IDLE;
          end else if (wd_expired) begin
            bus_err         <= 1'b1;
            cpu_rd_data     <= '0;
            bus.bus_req_    <= DISABLE_;
            bus.bus_rw      <= READ;
            bus.bus_addr    <= '0;
            bus.bus_wr_data <= '0;
            state           <= stall ? ST_STALL : ST_IDLE;
          end
        end

        ST_STALL: begin
          if (!stall) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_if.sv
// Self-checking bench for bus_master_if: a table of directed transactions,
// randomized transactions predicted by a transaction-level model, and
// hand-written flush and reset-in-access sequences.
module tb_bus_master_if;

  localparam int TIMEOUT = 8;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        cpu_req;
  logic        cpu_rw;
  logic [29:0] cpu_addr;
  logic [31:0] cpu_wr_data;
  logic [31:0] cpu_rd_data;
  logic        cpu_busy;
  logic        bus_err;

  int checks = 0;
  int errors = 0;
  int cur_txn = -1;
  logic [31:0] model_rd;

  typedef struct {
    logic        rw;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gdelay;
    int          rdelay;
    int          nstall;
    logic        flushmid;
    logic [31:0] exp_rd;
    logic        exp_err;
  } txn_t;

  txn_t vec [8];

  bus_master_if_if #(.ADDR_W(30), .DATA_W(32)) bus_i ();

  bus_master_if #(
    .ADDR_W  (30),
    .DATA_W  (32),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .cpu_req     (cpu_req),
    .cpu_rw      (cpu_rw),
    .cpu_addr    (cpu_addr),
    .cpu_wr_data (cpu_wr_data),
    .cpu_rd_data (cpu_rd_data),
    .cpu_busy    (cpu_busy),
    .bus_err     (bus_err),
    .bus         (bus_i)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic req, input logic rw, input logic [29:0] addr,
                               input logic [31:0] wdata, input logic fl, input logic st,
                               input logic grnt_, input logic rdy_, input logic [31:0] rdata);
    cpu_req           = req;
    cpu_rw            = rw;
    cpu_addr          = addr;
    cpu_wr_data       = wdata;
    flush             = fl;
    stall             = st;
    bus_i.bus_grnt_   = grnt_;
    bus_i.bus_rdy_    = rdy_;
    bus_i.bus_rd_data = rdata;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (txn %0d): got 0x%08h, expected 0x%08h", name, cur_txn, act, exp);
    end
  endtask

  // Transaction-level prediction: rdy_ arriving after the TIMEOUT-th access
  // cycle means an abort (error, data zeroed); writes keep the old data
  function automatic txn_t predict(input txn_t t, input logic [31:0] prev_rd);
    txn_t r;
    r = t;
    r.exp_err = (t.rdelay + 1 > TIMEOUT);
    r.exp_rd  = r.exp_err ? 32'h0 : (t.rw ? t.rdata : prev_rd);
    return r;
  endfunction

  task automatic runTxn(input txn_t t, input logic [31:0] prev_rd);
    int rdy_cycle;
    int nacc;
    logic [31:0] j;
    logic last;
    logic hit;
    rdy_cycle = t.rdelay + 1;
    nacc      = (rdy_cycle > TIMEOUT) ? TIMEOUT : rdy_cycle;

    nextCycle();
    applyStimulus(1'b1, t.rw, t.addr, t.wdata, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    checkOutput("idle_busy", 32'(cpu_busy), 32'd1);
    checkOutput("idle_req_", 32'(bus_i.bus_req_), 32'd1);
    checkOutput("idle_addr", 32'(bus_i.bus_addr), 32'h0);

    for (int i = 0; i <= t.gdelay; i++) begin
      nextCycle();
      j = $urandom();
      applyStimulus(1'b0, j[0], j[29:0], $urandom(), t.flushmid, 1'b0,
                    (i == t.gdelay) ? 1'b0 : 1'b1, 1'b1, $urandom());
      checkOutput("req_req_", 32'(bus_i.bus_req_), 32'd0);
      checkOutput("req_as_", 32'(bus_i.bus_as_), 32'd1);
      checkOutput("req_addr", 32'(bus_i.bus_addr), 32'h0);
      checkOutput("req_busy", 32'(cpu_busy), 32'd1);
    end

    for (int a = 1; a <= nacc; a++) begin
      last = (a == nacc);
      hit  = (a == rdy_cycle);
      nextCycle();
      j = $urandom();
      applyStimulus(1'b0, j[0], j[29:0], $urandom(), t.flushmid,
                    last && (t.nstall > 0), 1'b1, hit ? 1'b0 : 1'b1,
                    hit ? t.rdata : $urandom());
      checkOutput("acc_req_", 32'(bus_i.bus_req_), 32'd0);
      checkOutput("acc_as_", 32'(bus_i.bus_as_), (a == 1) ? 32'd0 : 32'd1);
      checkOutput("acc_addr", 32'(bus_i.bus_addr), 32'(t.addr));
      checkOutput("acc_rw", 32'(bus_i.bus_rw), 32'(t.rw));
      checkOutput("acc_wdata", bus_i.bus_wr_data, t.wdata);
      checkOutput("acc_busy", 32'(cpu_busy), 32'd1);
      checkOutput("acc_err", 32'(bus_err), 32'd0);
      checkOutput("acc_rd_hold", cpu_rd_data, prev_rd);
    end

    for (int p = 1; p <= t.nstall + 2; p++) begin
      nextCycle();
      applyStimulus(1'b0, 1'b1, 30'h0, 32'h0, 1'b0, (p < t.nstall) ? 1'b1 : 1'b0,
                    1'b1, 1'b1, $urandom());
      checkOutput("post_req_", 32'(bus_i.bus_req_), 32'd1);
      checkOutput("post_as_", 32'(bus_i.bus_as_), 32'd1);
      checkOutput("post_addr", 32'(bus_i.bus_addr), 32'h0);
      checkOutput("post_wdata", bus_i.bus_wr_data, 32'h0);
      checkOutput("post_busy", 32'(cpu_busy), 32'd0);
      checkOutput("post_rd", cpu_rd_data, t.exp_rd);
      checkOutput("post_err", 32'(bus_err), (p == 1) ? 32'(t.exp_err) : 32'd0);
    end
  endtask

  initial begin
    // rw, addr, wdata, rdata, gdelay, rdelay, nstall, flushmid, exp_rd, exp_err
    vec[0] = '{1'b1, 30'h40,       32'h0,        32'hDEADBEEF, 0, 0,  0, 1'b0, 32'hDEADBEEF, 1'b0};
    vec[1] = '{1'b0, 30'h100,      32'h12345678, 32'h55555555, 5, 0,  0, 1'b0, 32'hDEADBEEF, 1'b0};
    vec[2] = '{1'b1, 30'h2A,       32'h0,        32'hA5A50001, 1, 2,  0, 1'b1, 32'hA5A50001, 1'b0};
    vec[3] = '{1'b1, 30'h3FFFFFFF, 32'h0,        32'hFFFFFFFF, 0, 20, 0, 1'b0, 32'h0,        1'b1};
    vec[4] = '{1'b1, 30'h77,       32'h0,        32'h0BADF00D, 0, 1,  3, 1'b0, 32'h0BADF00D, 1'b0};
    vec[5] = '{1'b1, 30'h78,       32'h0,        32'hCAFE0008, 2, 7,  0, 1'b0, 32'hCAFE0008, 1'b0};
    vec[6] = '{1'b0, 30'h79,       32'h0F0F0F0F, 32'h11111111, 0, 20, 1, 1'b1, 32'h0,        1'b1};
    vec[7] = '{1'b0, 30'h7A,       32'hAAAA5555, 32'h22222222, 0, 3,  0, 1'b0, 32'h0,        1'b0};

    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 30'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    repeat (2) @(posedge clk);
    #2;
    checkOutput("rst_req_", 32'(bus_i.bus_req_), 32'd1);
    checkOutput("rst_as_", 32'(bus_i.bus_as_), 32'd1);
    checkOutput("rst_rw", 32'(bus_i.bus_rw), 32'd1);
    checkOutput("rst_addr", 32'(bus_i.bus_addr), 32'h0);
    checkOutput("rst_wdata", bus_i.bus_wr_data, 32'h0);
    checkOutput("rst_rd", cpu_rd_data, 32'h0);
    checkOutput("rst_err", 32'(bus_err), 32'd0);
    checkOutput("rst_busy", 32'(cpu_busy), 32'd0);
    reset = 1'b0;
    nextCycle();
    model_rd = 32'h0;

    $display("[TB] directed transaction table");
    for (int k = 0; k < 8; k++) begin
      cur_txn = k;
      runTxn(vec[k], model_rd);
      model_rd = vec[k].exp_rd;
    end

    $display("[TB] flush while requesting in IDLE");
    cur_txn = 100;
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      applyStimulus(1'b1, 1'b1, 30'h123, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("flush_busy", 32'(cpu_busy), 32'd0);
      checkOutput("flush_req_", 32'(bus_i.bus_req_), 32'd1);
    end
    nextCycle();
    applyStimulus(1'b0, 1'b1, 30'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    checkOutput("flush_req_after", 32'(bus_i.bus_req_), 32'd1);
    checkOutput("flush_rd_after", cpu_rd_data, model_rd);

    $display("[TB] randomized transactions");
    for (int k = 0; k < 24; k++) begin
      txn_t t;
      logic [31:0] r;
      r          = $urandom();
      t.rw       = r[0];
      t.flushmid = r[1];
      t.addr     = r[31:2];
      t.wdata    = $urandom();
      t.rdata    = $urandom();
      t.gdelay   = int'($urandom_range(0, 3));
      t.rdelay   = int'($urandom_range(0, 10));
      t.nstall   = int'($urandom_range(0, 2));
      t.exp_rd   = 32'h0;
      t.exp_err  = 1'b0;
      t          = predict(t, model_rd);
      cur_txn    = 200 + k;
      runTxn(t, model_rd);
      model_rd = t.exp_rd;
    end

    $display("[TB] reset during ACCESS");
    cur_txn = 300;
    nextCycle();
    applyStimulus(1'b1, 1'b1, 30'h55, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 30'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 30'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    checkOutput("rsta_as_", 32'(bus_i.bus_as_), 32'd0);
    nextCycle();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 30'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    nextCycle();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1, 30'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00001234);
    checkOutput("rsta_req_", 32'(bus_i.bus_req_), 32'd1);
    checkOutput("rsta_as_off", 32'(bus_i.bus_as_), 32'd1);
    checkOutput("rsta_addr", 32'(bus_i.bus_addr), 32'h0);
    checkOutput("rsta_busy", 32'(cpu_busy), 32'd0);
    checkOutput("rsta_rd", cpu_rd_data, 32'h0);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      applyStimulus(1'b0, 1'b1, 30'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00001234);
      checkOutput("rsta_late_req_", 32'(bus_i.bus_req_), 32'd1);
      checkOutput("rsta_late_as_", 32'(bus_i.bus_as_), 32'd1);
      checkOutput("rsta_late_rd", cpu_rd_data, 32'h0);
      checkOutput("rsta_late_err", 32'(bus_err), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
